// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB slave between NUM_REQ requesters.
// One transfer in flight at a time; completion is returned as a one-cycle rsp_valid pulse.
module apb_master_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                                pclk,
    input  logic                                preset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0]                  req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wdata,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   req_strb,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]               rsp_rdata,
    output logic                                rsp_err,
    output logic                                psel,
    output logic                                penable,
    output logic                                pwrite,
    output logic [ADDR_WIDTH-1:0]               paddr,
    output logic [DATA_WIDTH-1:0]               pwdata,
    output logic [DATA_WIDTH/8-1:0]             pstrb,
    input  logic [DATA_WIDTH-1:0]               prdata,
    input  logic                                pready,
    input  logic                                pslverr
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_WIDTH  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                 state;
    logic [IDX_WIDTH-1:0]   last_grant;
    logic [IDX_WIDTH-1:0]   owner;
    logic [CNT_WIDTH-1:0]   wait_cnt;

    logic                   sel_found;
    logic [IDX_WIDTH-1:0]   sel_idx;
    logic                   sel_write;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic [STRB_WIDTH-1:0]  sel_strb;
    logic                   timeout_hit;

    // Two ascending passes implement the wrapped search starting at last_grant+1.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!sel_found && (i > 32'(last_grant)) && req_valid[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_WIDTH'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!sel_found && (i <= 32'(last_grant)) && req_valid[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_WIDTH'(i);
            end
        end
    end

    assign sel_write = req_write[sel_idx];
    assign sel_addr  = req_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = req_wdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_strb  = req_strb[sel_idx*STRB_WIDTH +: STRB_WIDTH];

    // Withheld during reset so a requester never sees an accept that is discarded.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && sel_found && !preset) begin
            req_ready[sel_idx] = 1'b1;
        end
    end

    assign timeout_hit = (wait_cnt == CNT_WIDTH'(TIMEOUT - 1));

    always_ff @(posedge pclk) begin
        if (preset) begin
            state      <= IDLE;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            pstrb      <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            last_grant <= IDX_WIDTH'(NUM_REQ - 1);
            owner      <= '0;
            wait_cnt   <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        owner      <= sel_idx;
                        last_grant <= sel_idx;
                        pwrite     <= sel_write;
                        paddr      <= sel_addr;
                        pwdata     <= sel_write ? sel_wdata : '0;
                        pstrb      <= sel_write ? sel_strb : '0;
                        psel       <= 1'b1;
                        penable    <= 1'b0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready || timeout_hit) begin
                        psel             <= 1'b0;
                        penable          <= 1'b0;
                        wait_cnt         <= '0;
                        state            <= IDLE;
                        rsp_valid[owner] <= 1'b1;
                        rsp_err          <= pready ? pslverr : 1'b1;
                        rsp_rdata        <= (pready && !pslverr && !pwrite) ? prdata : '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
